// File: rtl/tt_um_rejunity_eca_if.sv
// Pin bundle for the elementary cellular automaton tile: the TinyTapeout user-project
// pins except clock and reset.
interface tt_um_rejunity_eca_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_rejunity_eca.sv
// Elementary cellular automaton engine: any Wolfram rule on a ring or padded strip,
// with 8-cell block access, a generation counter and a step-budget run mode.
module tt_um_rejunity_eca #(
  parameter int         NUM_CELLS  = 64,
  parameter logic [7:0] RESET_RULE = 8'd110
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tt_um_rejunity_eca_if.slave  io
);
  localparam int NB = NUM_CELLS / 8;

  localparam logic [5:0] ADDR_GEN    = 6'd59;
  localparam logic [5:0] ADDR_RULE   = 6'd60;
  localparam logic [5:0] ADDR_CFG    = 6'd61;
  localparam logic [5:0] ADDR_BUDGET = 6'd62;
  localparam logic [5:0] ADDR_ALIAS0 = 6'd63;

  logic [NUM_CELLS-1:0] cells;
  logic [NUM_CELLS-1:0] next_cells;
  logic [7:0]           rule;
  logic [2:0]           cfg;
  logic [7:0]           budget;
  logic [7:0]           gen;

  logic       write_enable_n;
  logic       halt_n;
  logic [5:0] address;
  logic [5:0] block_addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       step;
  logic       unused_ena;

  assign write_enable_n = io.uio_in[0];
  assign halt_n         = io.uio_in[1];
  assign address        = io.uio_in[7:2];
  assign data_in        = io.ui_in;
  assign unused_ena     = io.ena;

  // Address 63 folds onto block 0 so floating address pins still show live cells.
  assign block_addr = (address == ADDR_ALIAS0) ? 6'd0 : address;

  assign step = halt_n & write_enable_n & (~cfg[2] | (budget != 8'd0));

  // Neighbourhood index is {right, self, left}; out-of-range neighbours wrap or pad.
  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
    logic left;
    logic right;
    if (i == 0) begin : g_left_edge
      assign left = cfg[0] ? cells[NUM_CELLS-1] : cfg[1];
    end else begin : g_left_inner
      assign left = cells[i-1];
    end
    if (i == NUM_CELLS - 1) begin : g_right_edge
      assign right = cfg[0] ? cells[0] : cfg[1];
    end else begin : g_right_inner
      assign right = cells[i+1];
    end
    assign next_cells[i] = rule[{right, cells[i], left}];
  end

  // Register addresses take precedence over block addresses should they ever overlap.
  always_comb begin
    data_out = 8'h00;
    case (address)
      ADDR_GEN:    data_out = gen;
      ADDR_RULE:   data_out = rule;
      ADDR_CFG:    data_out = {5'b00000, cfg};
      ADDR_BUDGET: data_out = budget;
      default: begin
        for (int b = 0; b < NB; b++) begin
          if (block_addr == 6'(b)) data_out = next_cells[8*b +: 8];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cells  <= {{(NUM_CELLS-1){1'b0}}, 1'b1};
      rule   <= RESET_RULE;
      cfg    <= 3'b001;
      budget <= 8'd0;
      gen    <= 8'd0;
    end else if (!write_enable_n) begin
      case (address)
        ADDR_GEN:    ;
        ADDR_RULE:   rule   <= data_in;
        ADDR_CFG:    cfg    <= data_in[2:0];
        ADDR_BUDGET: budget <= data_in;
        default: begin
          for (int b = 0; b < NB; b++) begin
            if (block_addr == 6'(b)) cells[8*b +: 8] <= data_in;
          end
        end
      endcase
    end else if (step) begin
      cells <= next_cells;
      gen   <= gen + 8'd1;
      if (cfg[2]) budget <= budget - 8'd1;
    end
  end

  assign io.uo_out  = data_out;
  assign io.uio_out = 8'h00;
  assign io.uio_oe  = 8'h00;
endmodule

// File: tb/tb_tt_um_rejunity_eca.sv
// Randomized self-checking bench for the cellular automaton tile against a
// cell-array reference model evaluated straight from the rule number.
module tb_tt_um_rejunity_eca;
  localparam int NUM_CELLS = 64;
  localparam int NB        = NUM_CELLS / 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  tt_um_rejunity_eca_if io ();

  tt_um_rejunity_eca #(.NUM_CELLS(NUM_CELLS), .RESET_RULE(8'd110)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bit         m_cells [NUM_CELLS];
  logic [7:0] m_rule;
  logic [2:0] m_cfg;
  logic [7:0] m_budget;
  logic [7:0] m_gen;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
  endtask

  function automatic bit model_next(input int i);
    bit l, r;
    int idx;
    if (i == 0) l = m_cfg[0] ? m_cells[NUM_CELLS-1] : m_cfg[1];
    else        l = m_cells[i-1];
    if (i == NUM_CELLS - 1) r = m_cfg[0] ? m_cells[0] : m_cfg[1];
    else                    r = m_cells[i+1];
    idx = 4 * int'(r) + 2 * int'(m_cells[i]) + int'(l);
    return bit'((int'(m_rule) >> idx) & 1);
  endfunction

  function automatic logic [7:0] model_read(input int addr);
    int a;
    logic [7:0] v;
    if (addr == 59) return m_gen;
    if (addr == 60) return m_rule;
    if (addr == 61) return {5'b0, m_cfg};
    if (addr == 62) return m_budget;
    a = (addr == 63) ? 0 : addr;
    if (a >= NB) return 8'h00;
    v = 8'h00;
    for (int k = 0; k < 8; k++) v[k] = model_next(8 * a + k);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CELLS; i++) m_cells[i] = (i == 0);
    m_rule = 8'd110; m_cfg = 3'b001; m_budget = 8'd0; m_gen = 8'd0;
  endtask

  task automatic model_edge(input bit r, input bit we_n, input bit halt_n,
                            input int addr, input logic [7:0] data);
    bit nx [NUM_CELLS];
    int a;
    if (!r) begin
      model_reset();
    end else if (!we_n) begin
      a = (addr == 63) ? 0 : addr;
      if (addr == 60)      m_rule   = data;
      else if (addr == 61) m_cfg    = data[2:0];
      else if (addr == 62) m_budget = data;
      else if (addr != 59 && a < NB)
        for (int k = 0; k < 8; k++) m_cells[8 * a + k] = data[k];
    end else if (halt_n && (!m_cfg[2] || m_budget != 0)) begin
      for (int i = 0; i < NUM_CELLS; i++) nx[i] = model_next(i);
      m_cells = nx;
      m_gen = m_gen + 8'd1;
      if (m_cfg[2]) m_budget = m_budget - 8'd1;
    end
  endtask

  // One clock: drive, sample and check at the falling edge, then advance the model.
  task automatic cyc(input bit r, input bit we_n, input bit halt_n, input int addr,
                     input logic [7:0] data, output logic [7:0] obs);
    logic [5:0] a6;
    a6 = 6'(addr);
    rst_n     = r;
    io.ui_in  = data;
    io.uio_in = {a6, halt_n, we_n};
    @(negedge clk);
    obs = io.uo_out;
    check($sformatf("rd@%0d", addr), obs, model_read(addr));
    @(posedge clk);
    model_edge(r, we_n, halt_n, addr, data);
    #1;
  endtask

  task automatic wr(input int addr, input logic [7:0] data);
    logic [7:0] obs;
    cyc(1'b1, 1'b0, 1'b0, addr, data, obs);
  endtask

  task automatic rd(input int addr, output logic [7:0] obs);
    cyc(1'b1, 1'b1, 1'b0, addr, 8'h00, obs);
  endtask

  task automatic do_reset();
    logic [7:0] obs;
    rst_n = 1'b0;
    io.ui_in  = 8'h00;
    io.uio_in = 8'h00;
    @(posedge clk);
    model_reset();
    #1;
    cyc(1'b0, 1'b1, 1'b0, 0, 8'h00, obs);
  endtask

  initial begin
    logic [7:0] obs;
    logic [7:0] gen_before;
    bit r, we_n, halt_n;
    int addr;
    n_checks = 0;
    n_pass   = 0;
    io.ena   = 1'b1;

    do_reset();
    rd(0, obs);  check("reset_blk0", obs, 8'h03);
    rd(7, obs);  check("reset_blk7", obs, 8'h00);
    rd(60, obs); check("reset_rule", obs, 8'h6E);
    rd(61, obs); check("reset_cfg", obs, 8'h01);
    check("uio_out", io.uio_out, 8'h00);
    check("uio_oe", io.uio_oe, 8'h00);

    wr(60, 8'h5A);
    rd(0, obs);  check("r90_blk0", obs, 8'h02);
    rd(7, obs);  check("r90_blk7_wrap", obs, 8'h80);
    cyc(1'b1, 1'b1, 1'b1, 0, 8'h00, obs);
    rd(59, obs); check("gen_one_step", obs, 8'h01);

    do_reset();
    wr(61, 8'h00);
    wr(60, 8'h5A);
    rd(7, obs);  check("pad0_blk7", obs, 8'h00);
    wr(61, 8'h02);
    rd(7, obs);  check("pad1_blk7_msb", {7'b0, obs[7]}, 8'h01);

    do_reset();
    wr(61, 8'h05);
    wr(62, 8'h03);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1, i % NB, 8'h00, obs);
    rd(59, obs); check("budget_gen", obs, 8'h03);
    rd(62, obs); check("budget_zero", obs, 8'h00);
    for (int b = 0; b < NB; b++) rd(b, obs);

    wr(61, 8'h01);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 59, 8'h00, obs);
    gen_before = m_gen;
    cyc(1'b1, 1'b0, 1'b1, 2, 8'hFF, obs);
    rd(59, obs); check("wr_no_step_gen", obs, gen_before);
    rd(2, obs);

    // Budget write while stepping would otherwise occur: the write wins.
    wr(61, 8'h05);
    cyc(1'b1, 1'b0, 1'b1, 62, 8'h02, obs);
    rd(62, obs); check("budget_write_wins", obs, 8'h02);

    for (int t = 0; t < 800; t++) begin
      r      = !(t == 400 || t == 401);
      we_n   = ($urandom_range(0, 3) != 0);
      halt_n = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 1) addr = $urandom_range(0, NB - 1);
      else                           addr = $urandom_range(0, 63);
      if (!we_n && addr == 62) cyc(r, we_n, halt_n, addr, 8'($urandom_range(0, 12)), obs);
      else                     cyc(r, we_n, halt_n, addr, 8'($urandom_range(0, 255)), obs);
    end
    for (int a = 0; a < 64; a++) rd(a, obs);
    check("uio_out_end", io.uio_out, 8'h00);
    check("uio_oe_end", io.uio_oe, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
